// File: rtl/button_conditioner.sv
// button_conditioner
//   Input stage between the raw button pins and the stopwatch controller.
//   Each channel is synchronised (2 flops), debounced against a shared
//   millisecond-style tick, and turned into a clean level plus registered
//   1-cycle press / release / long-press strobes.
//   Default channel map: 0 = start_stop, 1 = lap_time, 2 = counter reset.
//
// Ports
//   clk          system clock
//   res          asynchronous reset, active low
//   btn_raw      raw button pins, asynchronous, active high
//   btn_level    debounced button level
//   btn_press    1-cycle strobe on accepted press
//   btn_release  1-cycle strobe on accepted release
//   btn_long     1-cycle strobe, once per press, after LONG_TICKS held
//   tick         1-cycle strobe every TICK_DIV cycles
//
// Per-channel FSM
//   state        | meaning
//   RELEASED     | stable low, level = 0
//   PRESS_PEND   | input high, waiting DEB_TICKS stable ticks before accepting
//   PRESSED      | stable high, level = 1, counting ticks towards long press
//   RELEASE_PEND | input low, waiting DEB_TICKS stable ticks before releasing
module button_conditioner #(
  parameter int N_BTN      = 3,
  parameter int TICK_DIV   = 1000,
  parameter int DEB_TICKS  = 10,
  parameter int LONG_TICKS = 1000,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             res,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (LONG_TICKS >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("button_conditioner: CNT_W too narrow to hold LONG_TICKS");
  end

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  logic [N_BTN-1:0] sync_q1, sync_q2;
  logic [PRE_W-1:0] pre_cnt;

  btn_state_t       state_q [N_BTN];
  btn_state_t       state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_d, press_d, release_d, long_d;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  // A change on the synchronised input always takes priority over a tick
  // arriving in the same cycle; that tick is simply not counted.
  always_comb begin
    level_d   = btn_level;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        RELEASED: begin
          if (sync_q2[i]) begin
            state_d[i] = PRESS_PEND;
            cnt_d[i]   = '0;
          end
        end
        PRESS_PEND: begin
          if (!sync_q2[i]) begin
            state_d[i] = RELEASED;
          end else if (tick) begin
            if (cnt_q[i] == DEB_LAST) begin
              state_d[i]    = PRESSED;
              cnt_d[i]      = '0;
              press_d[i]    = 1'b1;
              level_d[i]    = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        end
        PRESSED: begin
          if (!sync_q2[i]) begin
            state_d[i] = RELEASE_PEND;
            cnt_d[i]   = '0;
          end else if (tick && (cnt_q[i] < LONG_MAX)) begin
            // Saturating at LONG_TICKS makes the long strobe one-shot.
            cnt_d[i] = cnt_q[i] + CNT_ONE;
            if (cnt_q[i] == LONG_LAST) begin
              long_d[i] = 1'b1;
            end
          end
        end
        RELEASE_PEND: begin
          if (sync_q2[i]) begin
            // Release bounce: back to held, long-press timing restarts.
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == DEB_LAST) begin
              state_d[i]   = RELEASED;
              cnt_d[i]     = '0;
              release_d[i] = 1'b1;
              level_d[i]   = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_d;
    end
  end

endmodule
